fetch_pc_sequencer: RTL and testbench
=====================================

// Module: fetch_pc_sequencer
// PURPOSE
//  Owns the architectural fetch PC and sequences the fetch stage. Each cycle it picks the next PC from
//  the boot vector, the branch unit's correct PC (mispredict flush), its predicted PC, or the held PC.
//  It drives the I-mem request handshake and the IF/ID and ID/EX kill strobes, and keeps redirect and
//  stall statistics. Sits between the branch predict/resolve logic and the instruction-memory port.
// PARAMETERS
//  RESET_VEC  32'h0000_0000  first fetch address after reset
//  CNT_W      16             width of the saturating statistics counters
// PORTS
//  clk             in   1      core clock; all state changes on posedge
//  rstn            in   1      synchronous active-low reset
//  flush_i         in   1      mispredict detected in EX/MEM; redirect to correct_pc_i
//  correct_pc_i    in   32     resolved target, valid when flush_i=1
//  predict_pc_i    in   32     predicted next PC for the current pc_o
//  hazard_stall_i  in   1      load-use hazard; hold PC, no new fetch
//  halt_i          in   1      ecall/ebreak retired; stop fetching until reset
//  imem_ready_i    in   1      I-mem accepts the request this cycle
//  imem_req_o      out  1      fetch request for address pc_o
//  pc_o            out  32     current fetch address (registered)
//  if_valid_o      out  1      fetched word at pc_o is valid for IF/ID this cycle
//  kill_ifid_o     out  1      squash IF/ID register this edge
//  kill_idex_o     out  1      squash ID/EX register this edge
//  misalign_o      out  1      sticky: redirect target had pc[1:0]!=0
//  state_o         out  2      FSM state, for debug
//  redirect_cnt_o  out  CNT_W  number of flush redirects taken
//  stall_cnt_o     out  CNT_W  number of cycles the PC was held by stall or I-mem wait
// BEHAVIOUR
//  Reset (rstn=0 at posedge): state=BOOT, pc_o=RESET_VEC, misalign_o=0, both counters=0.
//   Outputs during BOOT: imem_req_o=0, if_valid_o=0, kills=0. Reset mid-operation aborts any pending request.
//  States: BOOT=0, RUN=1, WAIT=2, HALT=3.
//   BOOT -> RUN unconditionally after 1 cycle; pc_o stays RESET_VEC.
//   RUN/WAIT: imem_req_o=1.
//   HALT: imem_req_o=0, if_valid_o=0, kills=0, pc_o and counters frozen. Only reset exits HALT.
//  Next-PC priority in RUN/WAIT, highest first:
//   1 flush_i:
//     - correct_pc_i[1:0]!=0: set misalign_o, go to HALT, pc_o unchanged.
//     - otherwise: pc_o<=correct_pc_i, redirect_cnt++, next state RUN.
//   2 halt_i: go to HALT, pc_o unchanged.
//   3 hazard_stall_i, or !imem_ready_i: pc_o held, stall_cnt++.
//     Next state WAIT if !imem_ready_i, else RUN.
//   4 else: pc_o<=predict_pc_i, next state RUN.
//  Handshake: while imem_req_o && !imem_ready_i, pc_o is stable.
//   The only exception is flush_i, which abandons the request; the memory must tolerate this.
//  if_valid_o = imem_req_o & imem_ready_i & !flush_i & !hazard_stall_i (combinational).
//  kill_ifid_o = kill_idex_o = flush_i in RUN/WAIT (combinational, zero latency, same edge as redirect).
//  Simultaneous events:
//   - flush_i with hazard_stall_i: flush wins, the stall is not counted.
//   - flush_i with halt_i: flush wins. The halt is dropped because it came from the squashed path.
//  Counters saturate at {CNT_W{1'b1}} and never wrap.
//  PC arithmetic is not done here; the predictor supplies predict_pc_i. No wrap checks on pc_o.
// STRUCTURE
//  Package pc_seq_pkg:
//   - state localparams S_BOOT/S_RUN/S_WAIT/S_HALT (2-bit)
//   - PC_ALIGN_MASK=2'b11
//   - default RESET_VEC
//  Sub-module sat_counter #(CNT_W): inc, clr -> cnt. Instantiated twice (redirect, stall).
//  One FSM always-block plus one registered next-PC mux. Outputs if_valid/kill are combinational.
// TESTING
//  1 Reset 3 cycles, release -> BOOT for 1 cycle with pc_o=0 and req=0;
//    then RUN with req=1 and pc_o=0; cnts=0.
//  2 predict_pc_i=pc+4, imem_ready=1 for 4 cycles -> pc_o steps 0,4,8,C,10; if_valid=1 each cycle; stall_cnt=0.
//  3 imem_ready=0 for 3 cycles at pc=8 -> state WAIT, pc_o held at 8, stall_cnt=3, if_valid=0;
//    ready=1 -> pc_o=C.
//  4 flush_i=1, correct_pc_i=0x40, with hazard_stall_i=1 the same cycle -> kills=1 that cycle;
//    next pc_o=0x40; redirect_cnt=1; stall_cnt unchanged.
//  5 flush_i=1, correct_pc_i=0x42 -> misalign_o=1, state HALT, req=0;
//    further flushes are ignored; rstn=0 clears misalign_o.
//  6 halt_i=1 -> HALT with pc frozen. Separately, preload stall_cnt to 0xFFFF and stall 2 cycles
//    -> it stays at 0xFFFF.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch PC sequencer.
//   state_t          : fetch FSM encoding (BOOT=0, RUN=1, WAIT=2, HALT=3)
//   PC_ALIGN_MASK    : low PC bits that must be zero for a legal fetch target
//   DEFAULT_RESET_VEC: default first fetch address after reset
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [1:0]  PC_ALIGN_MASK     = 2'b11;
    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the sequencer statistics.
//   clk   : clock, all updates on posedge
//   i_clr : synchronous clear (highest priority)
//   i_inc : increment request; ignored once the counter is all-ones
//   o_cnt : current count
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: owns the architectural fetch PC, drives the I-mem
// request handshake and the IF/ID, ID/EX kill strobes, and keeps
// saturating redirect/stall statistics.
//   clk, rstn              : clock, synchronous active-low reset
//   flush_i, correct_pc_i  : mispredict redirect and its resolved target
//   predict_pc_i           : predicted next PC for the current pc_o
//   hazard_stall_i         : load-use hazard, hold PC
//   halt_i                 : stop fetching until reset
//   imem_ready_i           : I-mem accepts the request this cycle
//   imem_req_o, pc_o       : fetch request and its address
//   if_valid_o             : fetched word valid for IF/ID this cycle
//   kill_ifid_o/idex_o     : squash strobes, same cycle as flush_i
//   misalign_o             : sticky misaligned-redirect flag
//   state_o                : FSM state for debug
//   redirect_cnt_o         : flush redirects taken
//   stall_cnt_o            : cycles PC held by stall or I-mem wait
module fetch_pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush_i,
    input  logic [31:0]      correct_pc_i,
    input  logic [31:0]      predict_pc_i,
    input  logic             hazard_stall_i,
    input  logic             halt_i,
    input  logic             imem_ready_i,
    output logic             imem_req_o,
    output logic [31:0]      pc_o,
    output logic             if_valid_o,
    output logic             kill_ifid_o,
    output logic             kill_idex_o,
    output logic             misalign_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] redirect_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_misalign;

    logic        w_active;
    logic        w_flush;
    logic        w_target_bad;
    logic        w_hold;
    logic        w_redirect_inc;
    logic        w_stall_inc;
    logic [31:0] w_next_pc;

    assign w_active     = (r_state == S_RUN) || (r_state == S_WAIT);
    assign w_flush      = w_active && flush_i;
    assign w_target_bad = (correct_pc_i[1:0] & PC_ALIGN_MASK) != 2'b00;
    assign w_hold       = hazard_stall_i || !imem_ready_i;

    // A flush outranks halt and stall: the halt came from the squashed path,
    // and a stall coinciding with a redirect is not counted.
    assign w_redirect_inc = w_flush && !w_target_bad;
    assign w_stall_inc    = w_active && !flush_i && !halt_i && w_hold;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_BOOT;
            r_misalign <= 1'b0;
        end else begin
            unique case (r_state)
                S_BOOT: r_state <= S_RUN;
                S_RUN, S_WAIT: begin
                    if (flush_i) begin
                        if (w_target_bad) begin
                            r_misalign <= 1'b1;
                            r_state    <= S_HALT;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else if (halt_i) begin
                        r_state <= S_HALT;
                    end else if (!imem_ready_i) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_BOOT;
            endcase
        end
    end

    always_comb begin
        w_next_pc = r_pc;
        if (w_active) begin
            if (flush_i) begin
                if (!w_target_bad) w_next_pc = correct_pc_i;
            end else if (!halt_i && !w_hold) begin
                w_next_pc = predict_pc_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_pc <= RESET_VEC;
        else       r_pc <= w_next_pc;
    end

    sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .i_clr (!rstn),
        .i_inc (w_redirect_inc),
        .o_cnt (redirect_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .i_clr (!rstn),
        .i_inc (w_stall_inc),
        .o_cnt (stall_cnt_o)
    );

    assign imem_req_o  = w_active;
    assign pc_o        = r_pc;
    assign if_valid_o  = imem_req_o && imem_ready_i && !flush_i && !hazard_stall_i;
    assign kill_ifid_o = w_flush;
    assign kill_idex_o = w_flush;
    assign misalign_o  = r_misalign;
    assign state_o     = r_state;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
module tb_fetch_pc_sequencer;

    logic        clk;
    logic        rstn;
    logic        flush_i;
    logic [31:0] correct_pc_i;
    logic [31:0] predict_pc_i;
    logic        hazard_stall_i;
    logic        halt_i;
    logic        imem_ready_i;
    logic        imem_req_o;
    logic [31:0] pc_o;
    logic        if_valid_o;
    logic        kill_ifid_o;
    logic        kill_idex_o;
    logic        misalign_o;
    logic [1:0]  state_o;
    logic [15:0] redirect_cnt_o;
    logic [15:0] stall_cnt_o;

    int n_cmp;
    int n_err;

    fetch_pc_sequencer #(
        .RESET_VEC (32'h0000_0000),
        .CNT_W     (16)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .flush_i        (flush_i),
        .correct_pc_i   (correct_pc_i),
        .predict_pc_i   (predict_pc_i),
        .hazard_stall_i (hazard_stall_i),
        .halt_i         (halt_i),
        .imem_ready_i   (imem_ready_i),
        .imem_req_o     (imem_req_o),
        .pc_o           (pc_o),
        .if_valid_o     (if_valid_o),
        .kill_ifid_o    (kill_ifid_o),
        .kill_idex_o    (kill_idex_o),
        .misalign_o     (misalign_o),
        .state_o        (state_o),
        .redirect_cnt_o (redirect_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, returning to the falling edge where inputs change.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush_i        = 1'b0;
        correct_pc_i   = 32'h0;
        predict_pc_i   = 32'h0;
        hazard_stall_i = 1'b0;
        halt_i         = 1'b0;
        imem_ready_i   = 1'b1;
    endtask

    // Reset, then one edge through BOOT so the DUT sits in RUN at pc 0.
    task automatic reset_to_run();
        @(negedge clk);
        idle_inputs();
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rstn = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (state_o !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state_o); end
        n_cmp++;
        if (pc_o !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 00000000", pc_o); end
        n_cmp++;
        if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0 || kill_ifid_o !== 1'b0 || kill_idex_o !== 1'b0) begin
            n_err++; $display("FAIL rst_outs: got req=%b vld=%b k=%b%b want 0 0 00",
                              imem_req_o, if_valid_o, kill_ifid_o, kill_idex_o);
        end
        rstn = 1'b1;
        #1;
        n_cmp++;
        if (state_o !== 2'd0 || imem_req_o !== 1'b0) begin
            n_err++; $display("FAIL boot: got state=%0d req=%b want 0 0", state_o, imem_req_o);
        end
        tick();
        n_cmp++;
        if (state_o !== 2'd1 || imem_req_o !== 1'b1 || pc_o !== 32'h0) begin
            n_err++; $display("FAIL boot_to_run: got state=%0d req=%b pc=%h want 1 1 00000000",
                              state_o, imem_req_o, pc_o);
        end
        n_cmp++;
        if (redirect_cnt_o !== 16'h0 || stall_cnt_o !== 16'h0 || misalign_o !== 1'b0) begin
            n_err++; $display("FAIL rst_cnts: got rc=%h sc=%h mis=%b want 0000 0000 0",
                              redirect_cnt_o, stall_cnt_o, misalign_o);
        end
    endtask

    task automatic test_sequential_fetch();
        logic [31:0] exp_pc;
        reset_to_run();
        exp_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            predict_pc_i = exp_pc + 32'h4;
            #1;
            n_cmp++;
            if (if_valid_o !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %b want 1", i, if_valid_o); end
            tick();
            exp_pc = exp_pc + 32'h4;
            n_cmp++;
            if (pc_o !== exp_pc) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc_o, exp_pc); end
        end
        n_cmp++;
        if (stall_cnt_o !== 16'h0) begin n_err++; $display("FAIL seq_stall_cnt: got %h want 0000", stall_cnt_o); end
    endtask

    task automatic test_imem_wait();
        reset_to_run();
        predict_pc_i = 32'h4; tick();
        predict_pc_i = 32'h8; tick();
        imem_ready_i = 1'b0;
        predict_pc_i = 32'hC;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1) begin
                n_err++; $display("FAIL wait_vld[%0d]: got vld=%b req=%b want 0 1", i, if_valid_o, imem_req_o);
            end
            tick();
            n_cmp++;
            if (state_o !== 2'd2 || pc_o !== 32'h8) begin
                n_err++; $display("FAIL wait_hold[%0d]: got state=%0d pc=%h want 2 00000008", i, state_o, pc_o);
            end
        end
        n_cmp++;
        if (stall_cnt_o !== 16'd3) begin n_err++; $display("FAIL wait_stall_cnt: got %0d want 3", stall_cnt_o); end
        imem_ready_i = 1'b1;
        #1;
        n_cmp++;
        if (if_valid_o !== 1'b1) begin n_err++; $display("FAIL wait_release_vld: got %b want 1", if_valid_o); end
        tick();
        n_cmp++;
        if (pc_o !== 32'hC || state_o !== 2'd1) begin
            n_err++; $display("FAIL wait_release: got pc=%h state=%0d want 0000000c 1", pc_o, state_o);
        end
    endtask

    // Continues from test_imem_wait: pc=C, stall_cnt=3, redirect_cnt=0.
    task automatic test_flush();
        flush_i        = 1'b1;
        correct_pc_i   = 32'h40;
        hazard_stall_i = 1'b1;
        predict_pc_i   = 32'h10;
        #1;
        n_cmp++;
        if (kill_ifid_o !== 1'b1 || kill_idex_o !== 1'b1 || if_valid_o !== 1'b0) begin
            n_err++; $display("FAIL flush_kills: got k=%b%b vld=%b want 11 0", kill_ifid_o, kill_idex_o, if_valid_o);
        end
        tick();
        n_cmp++;
        if (pc_o !== 32'h40 || redirect_cnt_o !== 16'd1 || stall_cnt_o !== 16'd3) begin
            n_err++; $display("FAIL flush_redirect: got pc=%h rc=%0d sc=%0d want 00000040 1 3",
                              pc_o, redirect_cnt_o, stall_cnt_o);
        end
        hazard_stall_i = 1'b0;
        halt_i         = 1'b1;
        correct_pc_i   = 32'h80;
        tick();
        n_cmp++;
        if (pc_o !== 32'h80 || state_o !== 2'd1 || redirect_cnt_o !== 16'd2) begin
            n_err++; $display("FAIL flush_over_halt: got pc=%h state=%0d rc=%0d want 00000080 1 2",
                              pc_o, state_o, redirect_cnt_o);
        end
        halt_i  = 1'b0;
        flush_i = 1'b0;
        #1;
        n_cmp++;
        if (kill_ifid_o !== 1'b0 || kill_idex_o !== 1'b0) begin
            n_err++; $display("FAIL flush_kills_clear: got %b%b want 00", kill_ifid_o, kill_idex_o);
        end
    endtask

    // Continues from test_flush: pc=0x80, redirect_cnt=2.
    task automatic test_misalign();
        flush_i      = 1'b1;
        correct_pc_i = 32'h42;
        tick();
        n_cmp++;
        if (misalign_o !== 1'b1 || state_o !== 2'd3 || imem_req_o !== 1'b0 || pc_o !== 32'h80) begin
            n_err++; $display("FAIL misalign: got mis=%b state=%0d req=%b pc=%h want 1 3 0 00000080",
                              misalign_o, state_o, imem_req_o, pc_o);
        end
        correct_pc_i = 32'h100;
        #1;
        n_cmp++;
        if (kill_ifid_o !== 1'b0 || if_valid_o !== 1'b0) begin
            n_err++; $display("FAIL halt_kills: got k=%b vld=%b want 0 0", kill_ifid_o, if_valid_o);
        end
        tick();
        n_cmp++;
        if (pc_o !== 32'h80 || redirect_cnt_o !== 16'd2 || state_o !== 2'd3) begin
            n_err++; $display("FAIL halt_ignores_flush: got pc=%h rc=%0d state=%0d want 00000080 2 3",
                              pc_o, redirect_cnt_o, state_o);
        end
        flush_i = 1'b0;
        rstn    = 1'b0;
        tick();
        n_cmp++;
        if (misalign_o !== 1'b0 || state_o !== 2'd0 || redirect_cnt_o !== 16'd0) begin
            n_err++; $display("FAIL misalign_clear: got mis=%b state=%0d rc=%0d want 0 0 0",
                              misalign_o, state_o, redirect_cnt_o);
        end
        rstn = 1'b1;
    endtask

    task automatic test_halt();
        reset_to_run();
        predict_pc_i = 32'h4; tick();
        halt_i       = 1'b1;
        predict_pc_i = 32'h8;
        tick();
        n_cmp++;
        if (state_o !== 2'd3 || pc_o !== 32'h4 || imem_req_o !== 1'b0) begin
            n_err++; $display("FAIL halt_enter: got state=%0d pc=%h req=%b want 3 00000004 0",
                              state_o, pc_o, imem_req_o);
        end
        halt_i       = 1'b0;
        predict_pc_i = 32'h20;
        imem_ready_i = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (state_o !== 2'd3 || pc_o !== 32'h4 || if_valid_o !== 1'b0 || stall_cnt_o !== 16'd0) begin
            n_err++; $display("FAIL halt_frozen: got state=%0d pc=%h vld=%b sc=%0d want 3 00000004 0 0",
                              state_o, pc_o, if_valid_o, stall_cnt_o);
        end
    endtask

    task automatic test_stall_saturation();
        reset_to_run();
        hazard_stall_i = 1'b1;
        repeat (65534) tick();
        n_cmp++;
        if (stall_cnt_o !== 16'hFFFE || pc_o !== 32'h0) begin
            n_err++; $display("FAIL sat_pre: got sc=%h pc=%h want fffe 00000000", stall_cnt_o, pc_o);
        end
        tick();
        n_cmp++;
        if (stall_cnt_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach: got %h want ffff", stall_cnt_o); end
        imem_ready_i = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (stall_cnt_o !== 16'hFFFF || state_o !== 2'd2) begin
            n_err++; $display("FAIL sat_hold: got sc=%h state=%0d want ffff 2", stall_cnt_o, state_o);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential_fetch();
        test_imem_wait();
        test_flush();
        test_misalign();
        test_halt();
        test_stall_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
